// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg
// Shared RV32I constants: the base opcodes accepted by the instruction
// encoder (and reused by the ID-stage decoder), plus the loader session
// state encoding.
// No ports (package).
package rv_isa_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct3 values of the immediate shifts, which carry funct7 in the upper bits
    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

endpackage

// File: rtl/rv_instr_encode.sv
// rv_instr_encode
// Combinational packer: turns one field-level RV32I descriptor into its
// 32-bit instruction word. Opcodes outside the base table produce word=0
// and illegal=1.
// Ports:
//   opcode, rd, rs1, rs2, funct3, funct7 : descriptor fields
//   imm     : un-shifted, sign-extended immediate (imm[0] unused for B/J)
//   word    : encoded instruction
//   illegal : opcode not supported
module rv_instr_encode
    import rv_isa_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            OP_IMM: begin
                // Shift-immediates keep funct7 above a 5-bit shamt
                if (funct3 == F3_SLLI || funct3 == F3_SRLI_SRAI) begin
                    word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            OP_LOAD, OP_JALR: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
            end
            OP_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            OP_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            OP_LUI, OP_AUIPC: begin
                word = {imm[31:12], rd, opcode};
            end
            OP_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Builds programs in IMEM without an assembler: accepts RV32I descriptors,
// encodes each and writes it to consecutive word addresses from BASE_ADDR.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : begin a session (IDLE/DONE only)
//   in_valid/in_ready : descriptor handshake; in_ready = state is LOAD
//   in_*              : descriptor fields, in_last marks the final one
//   imem_we/addr/wdata: registered IMEM write port, one cycle per word
//   busy, done        : session status
//   err_illegal       : sticky, unsupported opcode seen
//   err_ovf           : sticky, IMEM end reached without in_last
//   count             : words written this session
module instr_encoder_loader
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_ovf,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_AD = {ADDR_W{1'b1}};

    load_state_e         state_q, state_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_ovf_q, err_ovf_d;

    logic [31:0]         enc_word;
    logic                enc_illegal;
    logic [ADDR_W-1:0]   wr_addr;

    rv_instr_encode u_encode (
        .opcode  (in_opcode),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // count only advances once a write has been issued, so a descriptor
    // accepted back-to-back behind a pending write must skip past it.
    assign wr_addr = BASE + count_q[ADDR_W-1:0] + ADDR_W'(imem_we_q);

    always_comb begin
        state_d       = state_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        count_d       = count_q;
        err_illegal_d = err_illegal_q;
        err_ovf_d     = err_ovf_q;

        if (imem_we_q) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new session wipes status even if the final write is in flight
                if (start) begin
                    state_d       = ST_LOAD;
                    count_d       = '0;
                    err_illegal_d = 1'b0;
                    err_ovf_d     = 1'b0;
                    imem_addr_d   = BASE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (enc_illegal) begin
                        err_illegal_d = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = wr_addr;
                        imem_wdata_d = enc_word;
                        if (in_last) begin
                            state_d = ST_DONE;
                        end else if (wr_addr == LAST_AD) begin
                            err_ovf_d = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= BASE;
            imem_wdata_q  <= 32'h0;
            count_q       <= '0;
            err_illegal_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            count_q       <= count_d;
            err_illegal_q <= err_illegal_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    assign in_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_LOAD) || imem_we_q;
    assign done        = (state_q == ST_DONE);
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign count       = count_q;
    assign err_illegal = err_illegal_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
// Directed bench: a 10-bit-address loader (a) covers encoding, sessions,
// errors and reset; a 2-bit-address loader (b) covers IMEM overflow.
// Both share the descriptor inputs and have separate start pulses.
module tb_instr_encoder_loader;
    import rv_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        in_valid;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;

    logic        ready_a, we_a, busy_a, done_a, ill_a, ovf_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [10:0] count_a;

    logic        ready_b, we_b, busy_b, done_b, ill_b, ovf_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .in_valid(in_valid), .in_ready(ready_a),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .busy(busy_a), .done(done_a), .err_illegal(ill_a), .err_ovf(ovf_a), .count(count_a)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .in_valid(in_valid), .in_ready(ready_b),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .err_illegal(ill_b), .err_ovf(ovf_b), .count(count_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic applyStimulus(input bit sel_b, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic last);
        int waited = 0;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid  = 1'b1;
        while (!(sel_b ? ready_b : ready_a) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!(sel_b ? ready_b : ready_a)) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic startSession(input bit sel_b);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Single-word encoding vectors (all with in_last)
    logic [6:0]  v_op  [6] = '{OP_IMM, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};
    logic [4:0]  v_rd  [6] = '{5'd5, 5'd1, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [4:0]  v_rs1 [6] = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0};
    logic [4:0]  v_rs2 [6] = '{5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0};
    logic [2:0]  v_f3  [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
    logic [31:0] v_imm [6] = '{32'hFFFFFFFF, 32'd3, 32'd8, 32'hFFFFFFFC, 32'd8, 32'h12345000};
    logic [31:0] v_exp [6] = '{32'hFFF00293, 32'h00309093, 32'h0020A423,
                               32'hFE208EE3, 32'h008000EF, 32'h123450B7};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0; in_last = 1'b0;

        @(negedge clk);
        checkOutput("rst_we",    32'(we_a),    32'd0);
        checkOutput("rst_addr",  32'(addr_a),  32'd0);
        checkOutput("rst_wdata", wdata_a,      32'd0);
        checkOutput("rst_count", 32'(count_a), 32'd0);
        checkOutput("rst_flags", {28'd0, done_a, ill_a, ovf_a, busy_a}, 32'd0);
        checkOutput("rst_ready", 32'(ready_a), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready", 32'(ready_a), 32'd0);
        startSession(1'b0);
        checkOutput("load_ready", 32'(ready_a), 32'd1);
        checkOutput("load_busy",  32'(busy_a),  32'd1);

        // ADD x3,x1,x2 as the only descriptor
        applyStimulus(1'b0, OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        checkOutput("add_we",    32'(we_a),   32'd1);
        checkOutput("add_addr",  32'(addr_a), 32'd0);
        checkOutput("add_wdata", wdata_a,     32'h002081B3);
        checkOutput("add_done",  32'(done_a), 32'd1);
        @(negedge clk);
        checkOutput("add_we_off", 32'(we_a),    32'd0);
        checkOutput("add_count",  32'(count_a), 32'd1);
        checkOutput("add_ready",  32'(ready_a), 32'd0);
        checkOutput("add_busy",   32'(busy_a),  32'd0);

        for (int i = 0; i < 6; i++) begin
            startSession(1'b0);
            applyStimulus(1'b0, v_op[i], v_rd[i], v_rs1[i], v_rs2[i], v_f3[i], 7'd0, v_imm[i], 1'b1);
            checkOutput($sformatf("enc%0d_we", i),    32'(we_a),   32'd1);
            checkOutput($sformatf("enc%0d_addr", i),  32'(addr_a), 32'd0);
            checkOutput($sformatf("enc%0d_wdata", i), wdata_a,     v_exp[i]);
        end
        @(negedge clk);

        // Six ADDI x(i+1),x0,i with gaps on odd indices; last on the sixth
        startSession(1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 1) repeat (i) @(negedge clk);
            applyStimulus(1'b0, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), i == 5);
            checkOutput($sformatf("seq%0d_we", i),    32'(we_a),    32'd1);
            checkOutput($sformatf("seq%0d_addr", i),  32'(addr_a),  32'(i));
            checkOutput($sformatf("seq%0d_count", i), 32'(count_a), 32'(i));
            checkOutput($sformatf("seq%0d_wdata", i), wdata_a,
                        (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13);
        end
        @(negedge clk);
        checkOutput("seq_count", 32'(count_a), 32'd6);
        checkOutput("seq_ready", 32'(ready_a), 32'd0);
        checkOutput("seq_done",  32'(done_a),  32'd1);

        // Illegal opcode ends the session with no write
        startSession(1'b0);
        applyStimulus(1'b0, 7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
        checkOutput("ill_we",   32'(we_a),   32'd0);
        checkOutput("ill_flag", 32'(ill_a),  32'd1);
        checkOutput("ill_done", 32'(done_a), 32'd1);
        checkOutput("ill_ovf",  32'(ovf_a),  32'd0);
        startSession(1'b0);
        checkOutput("restart_ill",   32'(ill_a),   32'd0);
        checkOutput("restart_done",  32'(done_a),  32'd0);
        checkOutput("restart_addr",  32'(addr_a),  32'd0);
        checkOutput("restart_count", 32'(count_a), 32'd0);
        checkOutput("restart_ready", 32'(ready_a), 32'd1);
        applyStimulus(1'b0, OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        checkOutput("restart_waddr", 32'(addr_a), 32'd0);
        checkOutput("restart_we",    32'(we_a),   32'd1);
        @(negedge clk);

        // Overflow on the 4-word instance: LUI xi,i<<12 without last
        startSession(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, OP_LUI, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i) << 12, 1'b0);
            checkOutput($sformatf("ovf%0d_we", i),    32'(we_b),   32'd1);
            checkOutput($sformatf("ovf%0d_addr", i),  32'(addr_b), 32'(i));
            checkOutput($sformatf("ovf%0d_wdata", i), wdata_b,
                        (32'(i) << 12) | (32'(i) << 7) | 32'h37);
            checkOutput($sformatf("ovf%0d_flag", i),  32'(ovf_b),  32'(i == 3));
            checkOutput($sformatf("ovf%0d_done", i),  32'(done_b), 32'(i == 3));
        end
        in_opcode = OP_LUI; in_rd = 5'd4; in_imm = 32'h4000; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("ovf5_we%0d", k),    32'(we_b),    32'd0);
            checkOutput($sformatf("ovf5_ready%0d", k), 32'(ready_b), 32'd0);
        end
        in_valid = 1'b0;
        checkOutput("ovf_count", 32'(count_b), 32'd4);
        checkOutput("ovf_ill",   32'(ill_b),   32'd0);

        // Reset asserted in the cycle after an accept drops the write
        startSession(1'b0);
        in_opcode = OP_R; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_last = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we",    32'(we_a),    32'd0);
        checkOutput("mid_rst_wdata", wdata_a,      32'd0);
        checkOutput("mid_rst_addr",  32'(addr_a),  32'd0);
        checkOutput("mid_rst_count", 32'(count_a), 32'd0);
        checkOutput("mid_rst_flags", {28'd0, done_a, ill_a, ovf_a, busy_a}, 32'd0);
        checkOutput("mid_rst_ready", 32'(ready_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_we", 32'(we_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
